rbe_output_register: RTL
========================

RBE_OUTPUT_REGISTER -- requirements
Module: rbe_output_register

Interface
REQ-001 SHALL have parameter TP, default rbe_package::BINCONV_TP, word width in bits.
REQ-002 SHALL have parameter NPR, default 8, number of buffer entries (≥2).
REQ-003 SHALL have parameter CNT_SIZE, default rbe_package::VLEN_CNT_SIZE, pointer/length width, with 2^CNT_SIZE ≥ NPR.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk_i input 1, rising-edge clock; rst_i input 1, asynchronous active-high reset.
REQ-005 SHALL have these ports:
- test_mode_i  input  1  DFT mode, no functional effect.
- enable_i  input  1  local enable.
- clear_i  input  1  synchronous clear.
- res_i  hwpe_stream_intf_stream.sink  TP  result words from compute.
- res_o  hwpe_stream_intf_stream.source  TP  result words towards streamer.
- ctrl_out_buf_i  input  rbe_package::ctrl_out_buf_t  goto_fill, goto_drain, fill_len[CNT_SIZE:0], drain_len[CNT_SIZE:0].
- flags_out_buf_o  output  rbe_package::flags_out_buf_t  state, words_valid[CNT_SIZE:0].

Function
REQ-006 SHALL implement FSM states OB_IDLE, OB_FILL, OB_DRAIN.
REQ-007 OB_IDLE: goto_fill -> OB_FILL; else goto_drain -> OB_DRAIN; goto_fill has priority when both are high; both SHALL be ignored in any other state.
REQ-008 Effective length SHALL be the requested length clamped to the range 1..NPR: 0 -> 1, >NPR -> NPR; applied independently to fill_len and drain_len, sampled every cycle.
REQ-009 OB_FILL: res_i.ready=1; on each res_i handshake, entry[wr_ptr] <= res_i.data and wr_ptr increments.
REQ-010 OB_FILL: a handshake with wr_ptr == eff_fill_len-1 SHALL write the last entry, clear wr_ptr, set words_valid=eff_fill_len and go to OB_IDLE in the same edge.
REQ-011 On entry to OB_FILL, words_valid SHALL be set to 0; words_valid SHALL otherwise hold.
REQ-012 OB_DRAIN: res_o.valid=1 and res_o.data=entry[rd_ptr], combinational from registers (zero latency); data and valid SHALL stay stable until handshake.
REQ-013 OB_DRAIN: each res_o handshake increments rd_ptr; a handshake with rd_ptr == eff_drain_len-1 SHALL clear rd_ptr and go to OB_IDLE.
REQ-014 Draining more words than words_valid SHALL be legal and output current (stale) entry contents; no error flag.
REQ-015 res_o.strb SHALL be all ones; res_i.strb SHALL be ignored.
REQ-016 res_i.ready=0 outside OB_FILL; res_o.valid=0 outside OB_DRAIN; res_o.data=entry[rd_ptr] at all times.
REQ-017 enable_i=0 SHALL freeze FSM, pointers, entries and words_valid, and force res_i.ready=0 and res_o.valid=0, so no handshake is lost.
REQ-018 clear_i=1 SHALL, at the next edge and regardless of enable_i, force OB_IDLE, clear wr_ptr, rd_ptr and words_valid, and zero all entries.
REQ-019 clear_i SHALL force res_i.ready=0 and res_o.valid=0 in the same cycle.
REQ-020 flags_out_buf_o.state SHALL equal the current FSM state.
REQ-021 Entries SHALL only be written by a handshake in OB_FILL; a drain SHALL never modify entries.

Reset
REQ-022 rst_i=1 SHALL asynchronously set the FSM to OB_IDLE, wr_ptr=rd_ptr=0, words_valid=0 and all entries to 0.
REQ-023 Output values during reset SHALL be res_i.ready=0, res_o.valid=0, res_o.data=0, res_o.strb all ones, state=OB_IDLE.
REQ-024 Reset asserted mid-FILL or mid-DRAIN SHALL abort the operation with no partial state retained.

Structure
REQ-025 rbe_package SHALL define state_out_buf_t, ctrl_out_buf_t and flags_out_buf_t.
REQ-026 Storage SHALL be NPR×TP enable flip-flops, with no latch storage and no sub-module required.
REQ-027 The optional read mux SHALL be a sub-module named rbe_output_register_mux.

Verification
REQ-028 Fill: NPR=8, fill_len=4, words 0xA0..0xA3 with continuous valid -> 4 handshakes, OB_IDLE on the 4th edge, words_valid=4.
REQ-029 Drain: drain_len=4, ready toggling 1,0,1,0 -> outputs 0xA0..0xA3 in order, data stable while ready=0, OB_IDLE after the 4th handshake.
REQ-030 Clamping: fill_len=0 -> single-word fill; drain_len=20 with NPR=8 -> exactly 8 words drained.
REQ-031 Freeze: drop enable_i after the 2nd fill handshake for 3 cycles -> ready=0 and pointers held; resume completes with words intact.
REQ-032 Mid-op abort: clear_i pulse during drain word 2 -> OB_IDLE next edge, entries read back as 0 on the next drain; repeat with rst_i asserted between clock edges -> immediate OB_IDLE.
REQ-033 Priority: goto_fill and goto_drain high together in OB_IDLE -> OB_FILL; goto_drain asserted during OB_FILL -> ignored.

Source files
------------

// File: rtl/rbe_package.sv
// Shared types for the RBE output buffer: FSM state, control and flag bundles.
// clamp_len bounds a requested word count into 1..max_len.
package rbe_package;

    localparam int unsigned BINCONV_TP    = 32;
    localparam int unsigned VLEN_CNT_SIZE = 8;

    typedef enum logic [1:0] {
        OB_IDLE  = 2'd0,
        OB_FILL  = 2'd1,
        OB_DRAIN = 2'd2
    } state_out_buf_t;

    typedef struct packed {
        logic                     goto_fill;
        logic                     goto_drain;
        logic [VLEN_CNT_SIZE:0]   fill_len;
        logic [VLEN_CNT_SIZE:0]   drain_len;
    } ctrl_out_buf_t;

    typedef struct packed {
        state_out_buf_t           state;
        logic [VLEN_CNT_SIZE:0]   words_valid;
    } flags_out_buf_t;

    function automatic logic [VLEN_CNT_SIZE:0] clamp_len(
        input logic [VLEN_CNT_SIZE:0] len,
        input logic [VLEN_CNT_SIZE:0] max_len
    );
        if (len == '0) begin
            return {{VLEN_CNT_SIZE{1'b0}}, 1'b1};
        end else if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready word stream with byte strobes; source drives valid/data/strb, sink drives ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/rbe_output_register_mux.sv
// Read mux selecting one buffer entry by pointer; out-of-range pointers read zero.
module rbe_output_register_mux #(
    parameter int unsigned TP       = 32,
    parameter int unsigned NPR      = 8,
    parameter int unsigned CNT_SIZE = 8
) (
    input  logic [NPR-1:0][TP-1:0] entries_i,
    input  logic [CNT_SIZE-1:0]    sel_i,
    output logic [TP-1:0]          data_o
);
    always_comb begin
        data_o = '0;
        for (int i = 0; i < int'(NPR); i++) begin
            if (sel_i == CNT_SIZE'(i)) begin
                data_o = entries_i[i];
            end
        end
    end
endmodule

// File: rtl/rbe_output_register.sv
// NPR-entry output buffer: fills from res_i, then drains to res_o with zero read latency.
// enable_i freezes everything and drops both handshakes; clear_i wipes state at the next edge.
module rbe_output_register
    import rbe_package::*;
#(
    parameter int unsigned TP       = BINCONV_TP,
    parameter int unsigned NPR      = 8,
    parameter int unsigned CNT_SIZE = VLEN_CNT_SIZE
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_mode_i,
    input  logic                   enable_i,
    input  logic                   clear_i,
    hwpe_stream_intf_stream.sink   res_i,
    hwpe_stream_intf_stream.source res_o,
    input  ctrl_out_buf_t          ctrl_out_buf_i,
    output flags_out_buf_t         flags_out_buf_o
);
    localparam int unsigned LW = VLEN_CNT_SIZE + 1;
    localparam int unsigned CW = CNT_SIZE + 1;
    localparam logic [LW-1:0] NPR_L = LW'(NPR);

    state_out_buf_t          state_q;
    logic [CNT_SIZE-1:0]     wr_ptr_q;
    logic [CNT_SIZE-1:0]     rd_ptr_q;
    logic [CW-1:0]           words_valid_q;
    logic [NPR-1:0][TP-1:0]  entry_q;

    logic [CW-1:0] eff_fill_len;
    logic [CW-1:0] eff_drain_len;
    logic          active;
    logic          in_hs;
    logic          out_hs;
    logic          last_wr;
    logic          last_rd;
    logic          unused_ok;

    assign eff_fill_len  = CW'(clamp_len(ctrl_out_buf_i.fill_len, NPR_L));
    assign eff_drain_len = CW'(clamp_len(ctrl_out_buf_i.drain_len, NPR_L));

    // Handshakes are gated here so a frozen or clearing cycle can never consume a word.
    assign active      = enable_i & ~clear_i;
    assign res_i.ready = active & (state_q == OB_FILL);
    assign res_o.valid = active & (state_q == OB_DRAIN);
    assign res_o.strb  = '1;

    assign in_hs   = res_i.valid & res_i.ready;
    assign out_hs  = res_o.valid & res_o.ready;
    assign last_wr = ({1'b0, wr_ptr_q} == eff_fill_len - CW'(1));
    assign last_rd = ({1'b0, rd_ptr_q} == eff_drain_len - CW'(1));

    rbe_output_register_mux #(
        .TP       (TP),
        .NPR      (NPR),
        .CNT_SIZE (CNT_SIZE)
    ) i_mux (
        .entries_i (entry_q),
        .sel_i     (rd_ptr_q),
        .data_o    (res_o.data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= OB_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            words_valid_q <= '0;
            entry_q       <= '0;
        end else if (clear_i) begin
            state_q       <= OB_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            words_valid_q <= '0;
            entry_q       <= '0;
        end else if (enable_i) begin
            case (state_q)
                OB_IDLE: begin
                    if (ctrl_out_buf_i.goto_fill) begin
                        state_q       <= OB_FILL;
                        wr_ptr_q      <= '0;
                        words_valid_q <= '0;
                    end else if (ctrl_out_buf_i.goto_drain) begin
                        state_q  <= OB_DRAIN;
                        rd_ptr_q <= '0;
                    end
                end
                OB_FILL: begin
                    if (in_hs) begin
                        for (int i = 0; i < int'(NPR); i++) begin
                            if (wr_ptr_q == CNT_SIZE'(i)) begin
                                entry_q[i] <= res_i.data;
                            end
                        end
                        if (last_wr) begin
                            wr_ptr_q      <= '0;
                            words_valid_q <= eff_fill_len;
                            state_q       <= OB_IDLE;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + CNT_SIZE'(1);
                        end
                    end
                end
                OB_DRAIN: begin
                    if (out_hs) begin
                        if (last_rd) begin
                            rd_ptr_q <= '0;
                            state_q  <= OB_IDLE;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + CNT_SIZE'(1);
                        end
                    end
                end
                default: state_q <= OB_IDLE;
            endcase
        end
    end

    assign flags_out_buf_o.state       = state_q;
    assign flags_out_buf_o.words_valid = LW'(words_valid_q);

    assign unused_ok = ^{test_mode_i, res_i.strb};
endmodule
